// File: rtl/multicycle_control.sv
// Multi-cycle controller for the single-bus MIPS-subset CPU.
// Registered state machine sequencing IF/ID/EXE/MEM/WB; control outputs decode from State and OpCode.
module multicycle_control (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] OpCode,
    input  logic       zero,
    input  logic       sign,
    output logic [3:0] State,
    output logic       PCWre,
    output logic       IRWre,
    output logic       InsMemRW,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic       ExtSel,
    output logic [2:0] ALUOp,
    output logic       RegWre,
    output logic [1:0] RegDst,
    output logic       WrRegDSrc,
    output logic       DBDataSrc,
    output logic       nRD,
    output logic       nWR,
    output logic [1:0] PCSrc
);

    localparam logic [3:0] sIF     = 4'd0;
    localparam logic [3:0] sID     = 4'd1;
    localparam logic [3:0] sEXE_AL = 4'd2;
    localparam logic [3:0] sWB_AL  = 4'd3;
    localparam logic [3:0] sEXE_BR = 4'd4;
    localparam logic [3:0] sEXE_LS = 4'd5;
    localparam logic [3:0] sMEM    = 4'd6;
    localparam logic [3:0] sWB_LD  = 4'd7;
    localparam logic [3:0] sHALT   = 4'd8;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b010000;
    localparam logic [5:0] OP_AND   = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_OR    = 6'b010011;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLTI  = 6'b011100;
    localparam logic [5:0] OP_SW    = 6'b100110;
    localparam logic [5:0] OP_LW    = 6'b100111;
    localparam logic [5:0] OP_BEQ   = 6'b110000;
    localparam logic [5:0] OP_BNE   = 6'b110001;
    localparam logic [5:0] OP_BLTZ  = 6'b110010;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    logic [3:0] state_r;
    logic [3:0] stateNext_s;

    function automatic logic isAluInstr(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_ADDIU, OP_ANDI, OP_AND,
            OP_ORI, OP_OR, OP_SLL, OP_SLTI:           isAluInstr = 1'b1;
            default:                                   isAluInstr = 1'b0;
        endcase
    endfunction

    // I-type ALU instructions write rt instead of rd.
    function automatic logic isITypeAlu(input logic [5:0] op);
        case (op)
            OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI: isITypeAlu = 1'b1;
            default:                            isITypeAlu = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] aluOpOf(input logic [5:0] op);
        case (op)
            OP_ADD, OP_ADDIU, OP_LW, OP_SW:    aluOpOf = 3'b000;
            OP_SUB, OP_BEQ, OP_BNE, OP_BLTZ:   aluOpOf = 3'b001;
            OP_SLL:                            aluOpOf = 3'b010;
            OP_OR, OP_ORI:                     aluOpOf = 3'b011;
            OP_AND, OP_ANDI:                   aluOpOf = 3'b100;
            OP_SLTI:                           aluOpOf = 3'b101;
            default:                           aluOpOf = 3'b000;
        endcase
    endfunction

    function automatic logic branchTaken(input logic [5:0] op, input logic z, input logic s);
        case (op)
            OP_BEQ:  branchTaken = z;
            OP_BNE:  branchTaken = ~z;
            OP_BLTZ: branchTaken = s;
            default: branchTaken = 1'b0;
        endcase
    endfunction

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_r <= sIF;
        end else begin
            state_r <= stateNext_s;
        end
    end

    // Opcode-only datapath selects, valid in every state.
    always_comb begin
        ALUSrcA  = (OpCode == OP_SLL);
        ALUSrcB  = isITypeAlu(OpCode) || (OpCode == OP_LW) || (OpCode == OP_SW);
        ExtSel   = !((OpCode == OP_ANDI) || (OpCode == OP_ORI));
        ALUOp    = aluOpOf(OpCode);
        InsMemRW = 1'b1;
        State    = state_r;
    end

    // Next-state and per-state control strobes.
    always_comb begin
        stateNext_s = sIF;
        PCWre       = 1'b0;
        IRWre       = 1'b0;
        RegWre      = 1'b0;
        nRD         = 1'b1;
        nWR         = 1'b1;
        PCSrc       = 2'b00;
        RegDst      = 2'b10;
        WrRegDSrc   = 1'b1;
        DBDataSrc   = 1'b0;
        case (state_r)
            sIF: begin
                IRWre       = 1'b1;
                stateNext_s = sID;
            end
            sID: begin
                case (OpCode)
                    OP_J: begin
                        PCWre = 1'b1;
                        PCSrc = 2'b11;
                    end
                    OP_JR: begin
                        PCWre = 1'b1;
                        PCSrc = 2'b10;
                    end
                    OP_JAL: begin
                        PCWre     = 1'b1;
                        PCSrc     = 2'b11;
                        RegWre    = 1'b1;
                        RegDst    = 2'b00;
                        WrRegDSrc = 1'b0;
                    end
                    OP_HALT:                 stateNext_s = sHALT;
                    OP_BEQ, OP_BNE, OP_BLTZ: stateNext_s = sEXE_BR;
                    OP_LW, OP_SW:            stateNext_s = sEXE_LS;
                    default: begin
                        if (isAluInstr(OpCode)) begin
                            stateNext_s = sEXE_AL;
                        end else begin
                            // Undefined opcode retires as a nop.
                            PCWre       = 1'b1;
                            stateNext_s = sIF;
                        end
                    end
                endcase
            end
            sEXE_AL: stateNext_s = sWB_AL;
            sWB_AL: begin
                RegWre = 1'b1;
                PCWre  = 1'b1;
                RegDst = isITypeAlu(OpCode) ? 2'b01 : 2'b10;
            end
            sEXE_BR: begin
                PCWre = 1'b1;
                PCSrc = branchTaken(OpCode, zero, sign) ? 2'b01 : 2'b00;
            end
            sEXE_LS: stateNext_s = sMEM;
            sMEM: begin
                if (OpCode == OP_SW) begin
                    nWR   = 1'b0;
                    PCWre = 1'b1;
                end else if (OpCode == OP_LW) begin
                    nRD         = 1'b0;
                    stateNext_s = sWB_LD;
                end else begin
                    stateNext_s = sIF;
                end
            end
            sWB_LD: begin
                nRD       = 1'b0;
                DBDataSrc = 1'b1;
                RegWre    = 1'b1;
                RegDst    = 2'b01;
                PCWre     = 1'b1;
            end
            sHALT:   stateNext_s = sHALT;
            default: stateNext_s = sIF;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected control words are queued
// per instruction and compared against the DUT each cycle.
module tb_multicycle_control;

    logic       CLK = 1'b0;
    logic       Reset = 1'b0;
    logic [5:0] OpCode = 6'b000000;
    logic       zero = 1'b0;
    logic       sign = 1'b0;
    logic [3:0] State;
    logic       PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel;
    logic [2:0] ALUOp;
    logic       RegWre;
    logic [1:0] RegDst;
    logic       WrRegDSrc, DBDataSrc, nRD, nWR;
    logic [1:0] PCSrc;

    typedef struct packed {
        logic [3:0] st;
        logic       pcWre;
        logic       irWre;
        logic       insMemRw;
        logic       regWre;
        logic       nRd;
        logic       nWr;
        logic [1:0] pcSrc;
        logic [1:0] regDst;
        logic       wrRegDSrc;
        logic       dbDataSrc;
        logic       aluSrcA;
        logic       aluSrcB;
        logic       extSel;
        logic [2:0] aluOp;
    } ctrl_t;

    ctrl_t expQ_s[$];
    int    checks_r = 0;
    int    failures_r = 0;

    multicycle_control dut (
        .CLK(CLK), .Reset(Reset), .OpCode(OpCode), .zero(zero), .sign(sign),
        .State(State), .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .ALUOp(ALUOp),
        .RegWre(RegWre), .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc),
        .nRD(nRD), .nWR(nWR), .PCSrc(PCSrc)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time budget");
        $fatal(1, "watchdog");
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r++;
        if (obs !== exp) begin
            failures_r++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic ctrl_t observed();
        ctrl_t o;
        o = '{st: State, pcWre: PCWre, irWre: IRWre, insMemRw: InsMemRW, regWre: RegWre,
              nRd: nRD, nWr: nWR, pcSrc: PCSrc, regDst: RegDst, wrRegDSrc: WrRegDSrc,
              dbDataSrc: DBDataSrc, aluSrcA: ALUSrcA, aluSrcB: ALUSrcB, extSel: ExtSel,
              aluOp: ALUOp};
        return o;
    endfunction

    // Expected control word with defaults and opcode-derived selects.
    function automatic ctrl_t mk(input logic [3:0] st, input logic [5:0] op);
        ctrl_t e;
        e = '0;
        e.st        = st;
        e.insMemRw  = 1'b1;
        e.nRd       = 1'b1;
        e.nWr       = 1'b1;
        e.regDst    = 2'b10;
        e.wrRegDSrc = 1'b1;
        e.aluSrcA   = (op == 6'b011000);
        e.aluSrcB   = (op inside {6'b000010, 6'b010000, 6'b010010, 6'b011100, 6'b100110, 6'b100111});
        e.extSel    = !(op inside {6'b010000, 6'b010010});
        if (op inside {6'b000001, 6'b110000, 6'b110001, 6'b110010}) e.aluOp = 3'b001;
        else if (op == 6'b011000)                                   e.aluOp = 3'b010;
        else if (op inside {6'b010011, 6'b010010})                  e.aluOp = 3'b011;
        else if (op inside {6'b010001, 6'b010000})                  e.aluOp = 3'b100;
        else if (op == 6'b011100)                                   e.aluOp = 3'b101;
        else                                                        e.aluOp = 3'b000;
        return e;
    endfunction

    task automatic compareOne(input string tag);
        ctrl_t e;
        if (expQ_s.size() == 0) begin
            checkVal({tag, "_qempty"}, 32'd1, 32'd0);
        end else begin
            e = expQ_s.pop_front();
            checkVal(tag, {10'd0, observed()}, {10'd0, e});
        end
    endtask

    // Compare queued cycles starting now, one per clock.
    task automatic drain(input string tag);
        compareOne(tag);
        while (expQ_s.size() > 0) begin
            @(negedge CLK);
            #1;
            compareOne(tag);
        end
    endtask

    task automatic nextCycle();
        @(negedge CLK);
        #1;
    endtask

    // Queue the full per-cycle expectation of one instruction starting in sIF.
    task automatic pushInstr(input logic [5:0] op, input logic z, input logic s);
        ctrl_t e;
        logic  taken;
        OpCode = op;
        zero   = z;
        sign   = s;
        #1;
        e = mk(4'd0, op); e.irWre = 1'b1; expQ_s.push_back(e);
        case (op)
            6'b111000, 6'b111001, 6'b111010: begin
                e = mk(4'd1, op);
                e.pcWre = 1'b1;
                e.pcSrc = (op == 6'b111001) ? 2'b10 : 2'b11;
                if (op == 6'b111010) begin
                    e.regWre = 1'b1; e.regDst = 2'b00; e.wrRegDSrc = 1'b0;
                end
                expQ_s.push_back(e);
            end
            6'b110000, 6'b110001, 6'b110010: begin
                expQ_s.push_back(mk(4'd1, op));
                taken = (op == 6'b110000) ? z : (op == 6'b110001) ? !z : s;
                e = mk(4'd4, op); e.pcWre = 1'b1; e.pcSrc = taken ? 2'b01 : 2'b00;
                expQ_s.push_back(e);
            end
            6'b100110: begin
                expQ_s.push_back(mk(4'd1, op));
                expQ_s.push_back(mk(4'd5, op));
                e = mk(4'd6, op); e.nWr = 1'b0; e.pcWre = 1'b1; expQ_s.push_back(e);
            end
            6'b100111: begin
                expQ_s.push_back(mk(4'd1, op));
                expQ_s.push_back(mk(4'd5, op));
                e = mk(4'd6, op); e.nRd = 1'b0; expQ_s.push_back(e);
                e = mk(4'd7, op); e.nRd = 1'b0; e.dbDataSrc = 1'b1; e.regWre = 1'b1;
                e.regDst = 2'b01; e.pcWre = 1'b1; expQ_s.push_back(e);
            end
            6'b111111: begin
                expQ_s.push_back(mk(4'd1, op));
                for (int i = 0; i < 20; i++) expQ_s.push_back(mk(4'd8, op));
            end
            6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
            6'b010010, 6'b010011, 6'b011000, 6'b011100: begin
                expQ_s.push_back(mk(4'd1, op));
                expQ_s.push_back(mk(4'd2, op));
                e = mk(4'd3, op); e.regWre = 1'b1; e.pcWre = 1'b1;
                e.regDst = (op inside {6'b000010, 6'b010000, 6'b010010, 6'b011100}) ? 2'b01 : 2'b10;
                expQ_s.push_back(e);
            end
            default: begin
                e = mk(4'd1, op); e.pcWre = 1'b1; expQ_s.push_back(e);
            end
        endcase
    endtask

    task automatic runInstr(input string tag, input logic [5:0] op, input logic z, input logic s);
        pushInstr(op, z, s);
        drain(tag);
        nextCycle();
    endtask

    initial begin
        ctrl_t e;
        // Reset held: sIF outputs.
        nextCycle();
        e = mk(4'd0, 6'b000000); e.irWre = 1'b1; expQ_s.push_back(e);
        drain("reset");
        Reset = 1'b1;

        runInstr("add",   6'b000000, 1'b0, 1'b0);
        runInstr("lw",    6'b100111, 1'b0, 1'b0);
        runInstr("beqT",  6'b110000, 1'b1, 1'b0);
        runInstr("beqN",  6'b110000, 1'b0, 1'b0);
        runInstr("bneT",  6'b110001, 1'b0, 1'b0);
        runInstr("bltzT", 6'b110010, 1'b1, 1'b1);
        runInstr("bltzN", 6'b110010, 1'b0, 1'b0);
        runInstr("jal",   6'b111010, 1'b0, 1'b0);
        runInstr("j",     6'b111000, 1'b0, 1'b0);
        runInstr("jr",    6'b111001, 1'b0, 1'b0);
        runInstr("addiu", 6'b000010, 1'b0, 1'b0);
        runInstr("andi",  6'b010000, 1'b0, 1'b0);
        runInstr("ori",   6'b010010, 1'b0, 1'b0);
        runInstr("sll",   6'b011000, 1'b0, 1'b0);
        runInstr("slti",  6'b011100, 1'b0, 1'b0);
        runInstr("or",    6'b010011, 1'b0, 1'b0);
        runInstr("sw",    6'b100110, 1'b0, 1'b0);
        runInstr("undef", 6'b101010, 1'b0, 1'b0);
        runInstr("sub",   6'b000001, 1'b0, 1'b0);

        // sw interrupted by reset in sMEM.
        pushInstr(6'b100110, 1'b0, 1'b0);
        drain("swRst");
        Reset = 1'b0;
        #1;
        e = mk(4'd0, 6'b100110); e.irWre = 1'b1; expQ_s.push_back(e);
        drain("rstAsync");
        nextCycle();
        expQ_s.push_back(e);
        drain("rstHeld");
        Reset = 1'b1;
        nextCycle();
        expQ_s.push_back(mk(4'd1, 6'b100110));
        drain("rstRelease");
        nextCycle();
        expQ_s.push_back(mk(4'd5, 6'b100110));
        drain("rstResume");
        nextCycle();
        e = mk(4'd6, 6'b100110); e.nWr = 1'b0; e.pcWre = 1'b1; expQ_s.push_back(e);
        drain("rstResumeMem");
        nextCycle();

        // halt held, then recovered by reset.
        pushInstr(6'b111111, 1'b0, 1'b0);
        drain("halt");
        Reset = 1'b0;
        #1;
        e = mk(4'd0, 6'b111111); e.irWre = 1'b1; expQ_s.push_back(e);
        drain("haltRst");
        nextCycle();
        Reset = 1'b1;
        runInstr("postHalt", 6'b000000, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle controller for the single-bus MIPS-subset CPU. It replaces per-instruction combinational decoding with a registered state machine that sequences each instruction through IF/ID/EXE/MEM/WB. It drives the PC, instruction register, register file, ALU, extender and data memory control points of the multi-cycle datapath.

## Interface
- No parameters.
- CLK  in  1  system clock, all state updates on rising edge.
- Reset  in  1  asynchronous, active-low; Reset=0 forces state to sIF immediately.
- OpCode  in  6  instruction opcode, taken from the instruction register output.
- zero  in  1  ALU result == 0.
- sign  in  1  ALU result bit 31.
- State  out  4  current state code, for debug and bench observation.
- PCWre  out  1  PC loads on the next edge.
- IRWre  out  1  instruction register loads on the next edge.
- InsMemRW  out  1  constant 1, instruction memory read.
- ALUSrcA  out  1  1 selects shamt, 0 selects rs.
- ALUSrcB  out  1  1 selects extended immediate, 0 selects rt.
- ExtSel  out  1  1 sign-extend, 0 zero-extend.
- ALUOp  out  3  000 add, 001 sub, 010 B<<A, 011 or, 100 and, 101 signed set-less-than.
- RegWre  out  1  register file write enable.
- RegDst  out  2  write register select: 00 $31, 01 rt, 10 rd.
- WrRegDSrc  out  1  write data: 0 PC+4, 1 DB.
- DBDataSrc  out  1  DB source: 0 ALU result, 1 data memory.
- nRD  out  1  data memory read, active-low.
- nWR  out  1  data memory write, active-low.
- PCSrc  out  2  next PC: 00 PC+4, 01 PC+4+(imm<<2), 10 rs, 11 jump target.

## Operation
- Opcodes:
  - add 000000, sub 000001, addiu 000010
  - andi 010000, and 010001, ori 010010, or 010011
  - sll 011000, slti 011100
  - sw 100110, lw 100111
  - beq 110000, bne 110001, bltz 110010
  - j 111000, jr 111001, jal 111010, halt 111111
- States and codes: sIF 0, sID 1, sEXE_AL 2, sWB_AL 3, sEXE_BR 4, sEXE_LS 5, sMEM 6, sWB_LD 7, sHALT 8.
- Default values, used in every state unless overridden:
  - PCWre=0, IRWre=0, RegWre=0, nRD=1, nWR=1, PCSrc=00
  - RegDst=10, WrRegDSrc=1, DBDataSrc=0
- Decode-driven outputs, valid in every state: ALUSrcA, ALUSrcB, ExtSel and ALUOp are pure functions of OpCode.
  - ALUSrcA=1 for sll only.
  - ALUSrcB=1 for addiu, andi, ori, slti, lw, sw.
  - ExtSel=0 for andi and ori.
  - ALUOp: add for add/addiu/lw/sw; sub for sub/beq/bne/bltz; and for and/andi; or for or/ori; 010 for sll; 101 for slti.
- sIF: IRWre=1. Next state sID.
- sID transitions:
  - j: PCWre=1, PCSrc=11, next sIF.
  - jr: PCWre=1, PCSrc=10, next sIF.
  - jal: PCWre=1, PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0, next sIF.
  - halt: next sHALT.
  - beq/bne/bltz: next sEXE_BR.
  - lw/sw: next sEXE_LS.
  - All defined ALU opcodes: next sEXE_AL.
  - Undefined opcode: PCWre=1, PCSrc=00, next sIF (executes as a nop).
- sEXE_AL: next sWB_AL.
- sWB_AL: RegWre=1, PCWre=1. RegDst=01 for I-type (addiu/andi/ori/slti), otherwise 10. Next sIF.
- sEXE_BR: PCWre=1, next sIF. PCSrc=01 when the branch is taken, else 00.
  - beq taken: zero=1.
  - bne taken: zero=0.
  - bltz taken: sign=1.
- sEXE_LS: next sMEM.
- sMEM:
  - sw: nWR=0, PCWre=1, next sIF.
  - lw: nRD=0, next sWB_LD.
- sWB_LD: nRD=0, DBDataSrc=1, RegWre=1, RegDst=01, PCWre=1, next sIF.
- sHALT: all defaults, including PCWre=0. Stays until Reset.
- Unreachable state codes 9–15: defaults, next sIF.

## Timing
- State is registered; all outputs are combinational from State and OpCode (Moore with opcode qualification).
- OpCode and zero/sign must be stable before the edge that ends the state that samples them.
- Reset: asynchronous entry to sIF. While Reset=0, outputs equal the sIF values: IRWre=1, all write enables inactive, nRD=nWR=1, PCWre=0.
  - Release is synchronous to the next CLK edge.
  - Reset mid-instruction abandons it; no partial write occurs after assertion.
- Cycles per instruction, PC updated exactly once on the final edge:
  - j/jr/jal: 2
  - branches: 3
  - ALU: 4
  - sw: 4
  - lw: 5
  - halt: 2 to reach sHALT, then PC frozen.
- PCWre and RegWre are never asserted in sIF or sHALT.
- nRD and nWR are never both 0.

## Test plan
- Reset=0 asserted mid-sMEM of a sw -> State=0 immediately, nWR=1; after release, State goes 0→1 on consecutive edges.
- OpCode=000000 (add) -> State sequence 0,1,2,3,0. RegWre=1, RegDst=10, PCWre=1 only in state 3.
- OpCode=100111 (lw) -> sequence 0,1,5,6,7,0. nRD=0 in states 6–7; in state 7 DBDataSrc=1 and RegDst=01.
- OpCode=110000 (beq): zero=1 -> PCSrc=01 with PCWre=1 in state 4. Repeat with zero=0 -> PCSrc=00.
- OpCode=111010 (jal) -> in state 1: RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11, PCWre=1; next state 0.
- OpCode=111111 (halt) -> State 8 held for 20 cycles with PCWre=0; undefined OpCode=101010 -> nop, 2 cycles.
